// File: rtl/id_stage_pipe.sv
// Pipelined RV32I-subset decode stage: register file, control decode and a registered
// ID/EX boundary with load-use stall, branch flush and write-through bypass.

package id_stage_pkg;
   typedef struct packed {
      logic       branch;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       alusrc;
      logic       regwrite;
      logic [1:0] aluop;
   } ctrl_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
endpackage

// Combinational opcode decode: control bits, operand usage and 32-bit immediate.
module id_decode
   import id_stage_pkg::*;
(
   input  logic [31:0] instr,
   output ctrl_t       ctrl,
   output logic        illegal,
   output logic        uses_rs1,
   output logic        uses_rs2,
   output logic [31:0] imm32
);
   always_comb begin
      ctrl     = '0;
      illegal  = 1'b0;
      uses_rs1 = 1'b1;
      uses_rs2 = 1'b0;
      imm32    = '0;
      unique case (instr[6:0])
         OP_R: begin
            ctrl     = '{branch:1'b0, memread:1'b0, memwrite:1'b0, memtoreg:1'b1,
                         alusrc:1'b0, regwrite:1'b1, aluop:2'b10};
            uses_rs2 = 1'b1;
         end
         OP_IALU: begin
            ctrl  = '{branch:1'b0, memread:1'b0, memwrite:1'b0, memtoreg:1'b1,
                      alusrc:1'b1, regwrite:1'b1, aluop:2'b11};
            imm32 = {{20{instr[31]}}, instr[31:20]};
         end
         OP_LOAD: begin
            ctrl  = '{branch:1'b0, memread:1'b1, memwrite:1'b0, memtoreg:1'b0,
                      alusrc:1'b1, regwrite:1'b1, aluop:2'b00};
            imm32 = {{20{instr[31]}}, instr[31:20]};
         end
         OP_STORE: begin
            ctrl     = '{branch:1'b0, memread:1'b0, memwrite:1'b1, memtoreg:1'b0,
                         alusrc:1'b1, regwrite:1'b0, aluop:2'b00};
            uses_rs2 = 1'b1;
            imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         end
         OP_BRANCH: begin
            ctrl     = '{branch:1'b1, memread:1'b0, memwrite:1'b0, memtoreg:1'b0,
                         alusrc:1'b0, regwrite:1'b0, aluop:2'b01};
            uses_rs2 = 1'b1;
            imm32    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         end
         default: begin
            illegal  = 1'b1;
            uses_rs1 = 1'b0;
         end
      endcase
   end
endmodule

// Register file with x0 hard-wired to zero and write-through on both read ports.
module id_regfile #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            we,
   input  logic [AW-1:0]   wa,
   input  logic [XLEN-1:0] wd,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2
);
   logic [NREGS-1:0][XLEN-1:0] regs;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 regs     <= '0;
      else if (we && wa != '0)    regs[wa] <= wd;
   end

   assign rd1 = (ra1 == '0) ? '0 : (we && wa == ra1) ? wd : regs[ra1];
   assign rd2 = (ra2 == '0) ? '0 : (we && wa == ra2) ? wd : regs[ra2];
endmodule

module id_stage_pipe
   import id_stage_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            if_valid,
   input  logic [31:0]     if_instr,
   input  logic [XLEN-1:0] if_pc,
   output logic            id_ready,
   input  logic            flush,
   input  logic            wb_we,
   input  logic [AW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rs1_data,
   output logic [XLEN-1:0] ex_rs2_data,
   output logic [XLEN-1:0] ex_imm,
   output logic [AW-1:0]   ex_rs1,
   output logic [AW-1:0]   ex_rs2,
   output logic [AW-1:0]   ex_rd,
   output logic [2:0]      ex_funct3,
   output logic            ex_funct7b5,
   output logic            ex_branch,
   output logic            ex_memread,
   output logic            ex_memwrite,
   output logic            ex_memtoreg,
   output logic            ex_alusrc,
   output logic            ex_regwrite,
   output logic [1:0]      ex_aluop,
   output logic            ex_illegal
);
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [AW-1:0]   rs1;
      logic [AW-1:0]   rs2;
      logic [AW-1:0]   rd;
      logic [2:0]      funct3;
      logic            funct7b5;
      ctrl_t           ctrl;
      logic            illegal;
   } idex_t;

   idex_t           idex_d, idex_q;
   ctrl_t           dec_ctrl;
   logic            dec_illegal, uses_rs1, uses_rs2;
   logic [31:0]     imm32;
   logic [AW-1:0]   rs1, rs2, rd;
   logic [XLEN-1:0] rs1_data, rs2_data;
   logic            hazard, take;

   assign rs1 = AW'(if_instr[19:15]);
   assign rs2 = AW'(if_instr[24:20]);
   assign rd  = AW'(if_instr[11:7]);

   id_decode u_dec (
      .instr    (if_instr),
      .ctrl     (dec_ctrl),
      .illegal  (dec_illegal),
      .uses_rs1 (uses_rs1),
      .uses_rs2 (uses_rs2),
      .imm32    (imm32)
   );

   id_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wb_we),
      .wa    (wb_rd),
      .wd    (wb_data),
      .ra1   (rs1),
      .ra2   (rs2),
      .rd1   (rs1_data),
      .rd2   (rs2_data)
   );

   // Stall only on a live load in EX whose rd feeds an operand this instruction really uses.
   assign hazard = if_valid && idex_q.valid && idex_q.ctrl.memread && (idex_q.rd != '0) &&
                   ((uses_rs1 && idex_q.rd == rs1) || (uses_rs2 && idex_q.rd == rs2));
   // Flush consumes the fetch word even when it would otherwise stall.
   assign id_ready = flush || !hazard;
   assign take     = if_valid && !flush && !hazard;

   always_comb begin
      idex_d = '0;
      if (take) begin
         idex_d.valid    = 1'b1;
         idex_d.pc       = if_pc;
         idex_d.rs1_data = rs1_data;
         idex_d.rs2_data = rs2_data;
         idex_d.imm      = XLEN'($signed(imm32));
         idex_d.rs1      = rs1;
         idex_d.rs2      = rs2;
         idex_d.rd       = rd;
         idex_d.funct3   = if_instr[14:12];
         idex_d.funct7b5 = if_instr[30];
         idex_d.ctrl     = dec_ctrl;
         idex_d.illegal  = dec_illegal;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) idex_q <= '0;
      else        idex_q <= idex_d;
   end

   assign ex_valid    = idex_q.valid;
   assign ex_pc       = idex_q.pc;
   assign ex_rs1_data = idex_q.rs1_data;
   assign ex_rs2_data = idex_q.rs2_data;
   assign ex_imm      = idex_q.imm;
   assign ex_rs1      = idex_q.rs1;
   assign ex_rs2      = idex_q.rs2;
   assign ex_rd       = idex_q.rd;
   assign ex_funct3   = idex_q.funct3;
   assign ex_funct7b5 = idex_q.funct7b5;
   assign ex_branch   = idex_q.ctrl.branch;
   assign ex_memread  = idex_q.ctrl.memread;
   assign ex_memwrite = idex_q.ctrl.memwrite;
   assign ex_memtoreg = idex_q.ctrl.memtoreg;
   assign ex_alusrc   = idex_q.ctrl.alusrc;
   assign ex_regwrite = idex_q.ctrl.regwrite;
   assign ex_aluop    = idex_q.ctrl.aluop;
   assign ex_illegal  = idex_q.illegal;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed scoreboard bench for id_stage_pipe: expectations queued at drive time,
// popped and compared one edge later.
module tb_id_stage_pipe;
   localparam int XLEN = 32, NREGS = 32, AW = 5;

   logic clk = 1'b0, rst_n = 1'b0;
   logic if_valid = 1'b0, flush = 1'b0, wb_we = 1'b0;
   logic [31:0] if_instr = '0, if_pc = '0, wb_data = '0;
   logic [AW-1:0] wb_rd = '0;
   logic id_ready, ex_valid, ex_funct7b5, ex_illegal;
   logic ex_branch, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_regwrite;
   logic [1:0] ex_aluop;
   logic [2:0] ex_funct3;
   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [AW-1:0] ex_rs1, ex_rs2, ex_rd;

   id_stage_pipe #(.XLEN(XLEN), .NREGS(NREGS)) dut (
      .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .id_ready(id_ready), .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
      .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
      .ex_funct7b5(ex_funct7b5), .ex_branch(ex_branch), .ex_memread(ex_memread),
      .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc),
      .ex_regwrite(ex_regwrite), .ex_aluop(ex_aluop), .ex_illegal(ex_illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        bubble;
      logic [31:0] pc, rs1d, rs2d, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [2:0]  f3;
      logic        f7b5;
      logic [7:0]  ctrl;
      logic        illegal;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] shadow [32];
   int          checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // {illegal, branch, memread, memwrite, memtoreg, alusrc, regwrite, aluop}
   function automatic logic [8:0] ctrl_of(input logic [6:0] op);
      case (op)
         7'b0110011: return 9'b0_000101_10;
         7'b0010011: return 9'b0_000111_11;
         7'b0000011: return 9'b0_010011_00;
         7'b0100011: return 9'b0_001010_00;
         7'b1100011: return 9'b0_100000_01;
         default:    return 9'b1_000000_00;
      endcase
   endfunction

   function automatic logic [31:0] rdval(input logic [4:0] r, input logic we,
                                         input logic [4:0] wr, input logic [31:0] wd);
      if (r == 5'd0) return 32'h0;
      if (we && wr == r) return wd;
      return shadow[r];
   endfunction

   function automatic logic [7:0] ex_ctrl();
      return {ex_branch, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_regwrite, ex_aluop};
   endfunction

   task automatic check_out(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         checks++; errors++;
         $error("FAIL %s scoreboard empty observed=%0d expected=1", tag, sb.size());
      end else begin
         e = sb.pop_front();
         chk({tag, " ex_valid"}, 32'(ex_valid), 32'(!e.bubble));
         chk({tag, " ctrl"}, 32'(ex_ctrl()), e.bubble ? 32'h0 : 32'(e.ctrl));
         chk({tag, " illegal"}, 32'(ex_illegal), e.bubble ? 32'h0 : 32'(e.illegal));
         if (!e.bubble) begin
            chk({tag, " pc"}, ex_pc, e.pc);
            chk({tag, " rs1_data"}, ex_rs1_data, e.rs1d);
            chk({tag, " rs2_data"}, ex_rs2_data, e.rs2d);
            chk({tag, " imm"}, ex_imm, e.imm);
            chk({tag, " rs1"}, 32'(ex_rs1), 32'(e.rs1));
            chk({tag, " rs2"}, 32'(ex_rs2), 32'(e.rs2));
            chk({tag, " rd"}, 32'(ex_rd), 32'(e.rd));
            chk({tag, " funct3"}, 32'(ex_funct3), 32'(e.f3));
            chk({tag, " funct7b5"}, 32'(ex_funct7b5), 32'(e.f7b5));
         end
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, " ex_valid"}, 32'(ex_valid), 32'h0);
      chk({tag, " pc"}, ex_pc, 32'h0);
      chk({tag, " rs1_data"}, ex_rs1_data, 32'h0);
      chk({tag, " rs2_data"}, ex_rs2_data, 32'h0);
      chk({tag, " imm"}, ex_imm, 32'h0);
      chk({tag, " regs"}, 32'({ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5}), 32'h0);
      chk({tag, " ctrl"}, 32'({ex_illegal, ex_ctrl()}), 32'h0);
      chk({tag, " id_ready"}, 32'(id_ready), 32'h1);
   endtask

   task automatic step(input string tag, input logic v, input logic [31:0] instr,
                       input logic [31:0] pc, input logic fl, input logic we,
                       input logic [4:0] wr, input logic [31:0] wd,
                       input logic exp_ready, input logic [31:0] exp_imm);
      exp_t       e;
      logic [8:0] c;
      @(negedge clk);
      if_valid = v; if_instr = instr; if_pc = pc; flush = fl;
      wb_we = we; wb_rd = wr; wb_data = wd;
      #1 chk({tag, " id_ready"}, 32'(id_ready), 32'(exp_ready));
      c         = ctrl_of(instr[6:0]);
      e.bubble  = !v || fl || !exp_ready;
      e.pc      = pc;
      e.rs1     = instr[19:15];
      e.rs2     = instr[24:20];
      e.rd      = instr[11:7];
      e.f3      = instr[14:12];
      e.f7b5    = instr[30];
      e.rs1d    = rdval(instr[19:15], we, wr, wd);
      e.rs2d    = rdval(instr[24:20], we, wr, wd);
      e.imm     = exp_imm;
      e.ctrl    = c[7:0];
      e.illegal = c[8];
      sb.push_back(e);
      @(posedge clk);
      if (we && wr != 5'd0) shadow[wr] = wd;
      #1 check_out(tag);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) shadow[i] = 32'h0;
      repeat (2) @(negedge clk);
      #1 check_reset("reset");
      rst_n = 1'b1;

      step("wb_x22",       0, 32'h0,        32'h000, 0, 1, 5'd22, 32'h0000_1000, 1, 32'h0);
      step("add_bypass",   1, 32'h00A98933, 32'h100, 0, 1, 5'd19, 32'hDEAD_BEEF, 1, 32'h0);
      step("lw1",          1, 32'h020B2483, 32'h104, 0, 0, 5'd0,  32'h0,         1, 32'h20);
      step("lw2",          1, 32'h020B2483, 32'h108, 0, 0, 5'd0,  32'h0,         1, 32'h20);
      step("add_stall",    1, 32'h001482B3, 32'h10C, 0, 0, 5'd0,  32'h0,         0, 32'h0);
      step("add_issue",    1, 32'h001482B3, 32'h10C, 0, 1, 5'd9,  32'hCAFE_0009, 1, 32'h0);
      step("sw",           1, 32'hFEA12E23, 32'h110, 0, 0, 5'd0,  32'h0,         1, 32'hFFFF_FFFC);
      step("beq",          1, 32'hFE208CE3, 32'h114, 0, 0, 5'd0,  32'h0,         1, 32'hFFFF_FFF8);
      step("x0_write",     1, 32'h00500093, 32'h118, 0, 1, 5'd0,  32'h1234_5678, 1, 32'h5);
      step("illegal",      1, 32'h0000007F, 32'h11C, 0, 0, 5'd0,  32'h0,         1, 32'h0);
      step("lw3",          1, 32'h020B2483, 32'h120, 0, 0, 5'd0,  32'h0,         1, 32'h20);
      step("flush_hazard", 1, 32'h001482B3, 32'h124, 1, 0, 5'd0,  32'h0,         1, 32'h0);
      step("after_flush",  1, 32'h001482B3, 32'h128, 0, 0, 5'd0,  32'h0,         1, 32'h0);
      step("lw4",          1, 32'h020B2483, 32'h12C, 0, 0, 5'd0,  32'h0,         1, 32'h20);

      // Stall in progress with a live load in EX, then reset between edges.
      @(negedge clk);
      if_valid = 1'b1; if_instr = 32'h001482B3; if_pc = 32'h130; flush = 1'b0; wb_we = 1'b0;
      #1 chk("stall_before_reset id_ready", 32'(id_ready), 32'h0);
      #2 rst_n = 1'b0;
      #1 check_reset("async_reset");
      sb.delete();
      for (int i = 0; i < 32; i++) shadow[i] = 32'h0;
      @(posedge clk);
      #1 check_reset("reset_held");
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("post_release id_ready", 32'(id_ready), 32'h1);
      step("post_reset", 1, 32'h00998933, 32'h200, 0, 0, 5'd0, 32'h0, 1, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised, pipelined instruction-decode stage for the RV32I-subset core. It holds the register file and control decode behind a registered ID/EX boundary, and it adds features the single-cycle decoder lacks:
- valid/ready flow from fetch
- load-use hazard stall with bubble insertion
- branch flush
- write-through register-file bypass
- illegal-opcode flagging

It sits between the fetch stage and the execute stage.

## Interface
Parameters:
- XLEN, 32, datapath and register width
- NREGS, 32, architectural register count; AW = $clog2(NREGS) is the register-index width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  fetch presents an instruction
- if_instr  in  32  instruction word
- if_pc  in  XLEN  instruction address
- id_ready  out  1  ID accepts if_instr this cycle; 0 = IF must hold
- flush  in  1  branch taken in EX; kill the instruction entering ID/EX
- wb_we  in  1  write-back enable
- wb_rd  in  AW  write-back destination
- wb_data  in  XLEN  write-back value
- ex_valid  out  1  ID/EX register holds a live instruction
- ex_pc  out  XLEN  registered if_pc
- ex_rs1_data, ex_rs2_data  out  XLEN  register operands
- ex_imm  out  XLEN  sign-extended immediate
- ex_rs1, ex_rs2, ex_rd  out  AW  register indices
- ex_funct3  out  3  instr[14:12]
- ex_funct7b5  out  1  instr[30]
- ex_branch, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_regwrite  out  1 each  control bits
- ex_aluop  out  2  ALU operation class
- ex_illegal  out  1  unsupported opcode

## Operation
- **Register file:** NREGS x XLEN.
  - Written on the clk rising edge when wb_we=1 and wb_rd!=0; writes to x0 are discarded.
  - x0 always reads 0.
  - Same-cycle read of wb_rd (wb_we=1, wb_rd!=0) returns wb_data (write-through).
- **Control decode** (branch, memread, memwrite, memtoreg, alusrc, regwrite, aluop):
  - R 0110011: 0,0,0,1,0,1,10
  - I-ALU 0010011: 0,0,0,1,1,1,11
  - LOAD 0000011: 0,1,0,0,1,1,00
  - STORE 0100011: 0,0,1,0,1,0,00
  - BRANCH 1100011: 1,0,0,0,0,0,01
  - Any other opcode: all controls 0, ex_illegal=1.
  - memtoreg=1 selects the ALU result and 0 selects memory data; this convention is fixed core-wide.
- **Immediates:**
  - I-type for I-ALU/LOAD; S-type for STORE; B-type for BRANCH, with bit0 = 0.
  - All are sign-extended from instr[31] to XLEN.
  - R-type and illegal opcodes produce 0.
- **Register usage:**
  - rs1 is used by all legal opcodes.
  - rs2 is used by R, STORE and BRANCH only.
- **Load-use hazard:** hazard = ex_valid & ex_memread & ex_rd!=0 & ((usesrs1 & ex_rd==rs1) | (usesrs2 & ex_rd==rs2)), qualified by if_valid.
  - On hazard: id_ready=0, and a bubble is written to ID/EX.
  - Bubble = ex_valid=0, all controls 0, ex_illegal=0.
  - IF holds the instruction; the next cycle re-decodes it with no hazard, because the ID/EX register now holds the bubble.
- **Flush:**
  - On flush=1, the next ID/EX content is a bubble.
  - id_ready=1, so the fetch word is consumed and discarded.
  - Flush has priority over hazard.
- **No fetch:** if_valid=0 loads a bubble.
- **Illegal opcodes:** with if_valid=1, the instruction loads with ex_valid=1 and ex_illegal=1; EX raises the trap.

## Timing
- **Latency:** all ex_* outputs are registered, with 1-cycle latency from the if_* sample edge.
- **id_ready:** combinational from the ID/EX register and if_instr; no combinational path from wb_*.
- **Reset:** rst_n=0 asynchronously clears:
  - all ex_* outputs to 0
  - all registers x0..x(NREGS-1) to 0

  Release is synchronous to clk on the next edge.
- **Reset mid-stall:** after release, ex_valid=0 and id_ready=1.
- **Load-use:** exactly one bubble cycle per load-use pair. Back-to-back loads to the same rd used by the next instruction also stall exactly once.
- **Flush and hazard together:** flush wins; no extra stall cycle.
- **Write-back:** a write and a bypass read in the same cycle are both visible at the next edge.

## Test plan
1. Reset, then write wb_rd=19 with wb_data=0xDEADBEEF in the same cycle as if_instr=0x00A98933 (add x18,x19,x10) -> next cycle:
   - ex_valid=1, ex_rs1_data=0xDEADBEEF, ex_rs2_data=0, ex_rd=18
   - controls 0,0,0,1,0,1, aluop=10
2. if_instr=0x020B2483 (lw x9,32(x22)) -> ex_imm=0x00000020, ex_rs1=22, memread=1, alusrc=1, regwrite=1, memtoreg=0, aluop=00. Next, if_instr=0x001482B3 (add x5,x9,x1):
   - first cycle: id_ready=0, bubble in ID/EX (ex_valid=0)
   - following cycle: id_ready=1, add issues with ex_rs1=9
3. if_instr=0xFEA12E23 (sw x10,-4(x2)) -> ex_imm=0xFFFFFFFC, memwrite=1, regwrite=0. Then if_instr=0xFE208CE3 (beq x1,x2,-8) -> ex_imm=0xFFFFFFF8, branch=1, aluop=01.
4. wb_we=1, wb_rd=0, wb_data=0x12345678, then read x0 -> ex_rs1_data=0. Also issue opcode 0x0000007F -> ex_illegal=1, all controls 0.
5. Load-use condition plus flush=1 in the same cycle -> id_ready=1 and ex_valid=0 next cycle, with no extra stall cycle.
6. Assert rst_n=0 asynchronously between edges while ex_valid=1 -> all ex_* go to 0 immediately; previously written registers read 0 after release.
